pkt_fifo_sf: RTL
================

# pkt_fifo_sf

Parametrised store-and-forward AXI-Stream packet FIFO with whole-packet drop, the next generation of the team's packet queue. Ingress never backpressures: a packet that overflows the buffer, or that ends with its error flag set, is discarded in full by rolling back the write pointer. Only committed, complete packets are presented on the egress port, at full throughput. The block sits between a MAC/RX datapath and downstream parsers.

## Interface
- C_DATA_WIDTH, 256, tdata width in bits.
- C_MTY_WIDTH, 5, tuser_mty width: number of empty bytes on the tlast beat.
- C_DEPTH_BITS, 9, log2 of the buffer depth in beats; depth = 2^C_DEPTH_BITS.
- C_CNT_WIDTH, 32, width of the saturating drop counter.
- aclk  in  1  clock, the single clock domain.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tvalid / s_axis_tdata / s_axis_tlast / s_axis_tuser_mty  in  1 / C_DATA_WIDTH / 1 / C_MTY_WIDTH  ingress beat.
- s_axis_tuser_err  in  1  sampled on the tlast beat; 1 means discard the packet.
- s_axis_tready  out  1  constant 1 outside reset; 0 while aresetn is low.
- m_axis_tvalid / m_axis_tdata / m_axis_tlast / m_axis_tuser_mty  out  1 / C_DATA_WIDTH / 1 / C_MTY_WIDTH  egress beat.
- m_axis_tready  in  1  egress backpressure.
- fill_level  out  C_DEPTH_BITS+1  beats held in RAM, committed plus in-flight.
- pkt_count  out  C_DEPTH_BITS+1  committed packets not yet fully read out.
- drop_count  out  C_CNT_WIDTH  dropped packets; saturates at all-ones.
- drop_pulse  out  1  one-cycle pulse per dropped packet.

## Operation
- **Pointers.** Pointers are C_DEPTH_BITS+1 bits wide: wr_p (speculative), wr_commit, rd_p. The RAM address is the low C_DEPTH_BITS bits.
  - Full: wr_p - rd_p == 2^C_DEPTH_BITS.
  - Committed data present: rd_p != wr_commit.
  - All arithmetic is modulo 2^(C_DEPTH_BITS+1); wrap-around is transparent.
- **Write FSM** has two states, ACCEPT and DISCARD.
  - ACCEPT, beat arrives, not full: write {tdata, tlast, mty} at wr_p, then wr_p+1.
  - On a tlast beat with err=0: wr_commit <= wr_p+1 and pkt_count increments.
  - On a tlast beat with err=1: wr_p <= wr_commit and the drop is counted.
  - ACCEPT, beat arrives, full: wr_p <= wr_commit and the beat is discarded. If the beat is tlast, count the drop and stay in ACCEPT; otherwise go to DISCARD.
  - DISCARD: discard every beat. On tlast, count the drop and return to ACCEPT.
- A packet longer than 2^C_DEPTH_BITS beats is always dropped.
- **Drop accounting.** Exactly one drop_pulse and one drop_count increment per dropped packet, issued on the cycle after its tlast beat.
- **Read side.** Prefetch from the 1-cycle-latency RAM into a 2-entry output skid buffer. Reads are issued only while committed data is present and a skid slot is free or freeing.
- pkt_count decrements on the handshake of an m_axis tlast beat. A simultaneous commit and readout leaves pkt_count unchanged.
- **Reset values.** All pointers, pkt_count, fill_level and drop_count are 0; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser_mty=0, drop_pulse=0, s_axis_tready=0, FSM in ACCEPT.
  - Reset mid-packet loses the partial packet silently; it is not counted.
  - After release, the first beat is treated as the start of a packet.

## Timing
- Latency: tlast accepted at edge E, egress empty → m_axis_tvalid high after edge E+3.
- Throughput: one beat per cycle in each direction sustained, including back-to-back packets and the commit/read boundary.
- m_axis data is stable while m_axis_tvalid=1 and m_axis_tready=0 (AXI-Stream rule).
- Egress never shows a beat of an uncommitted or dropped packet.
- fill_level, pkt_count and drop_count update one cycle after the causing edge.

## Structure
- Package pkt_fifo_pkg holds:
  - the write FSM state enum {ACCEPT, DISCARD};
  - the beat record type {data, last, mty} and its width constant;
  - a pointer-width function of C_DEPTH_BITS.
- Sub-module pkt_fifo_ram: simple dual-port inferred RAM with a registered read and 1-cycle read latency. It holds no control logic.

## Test plan
Settings for all scenarios: C_DATA_WIDTH=8, C_MTY_WIDTH=3, C_DEPTH_BITS=4 (depth 16).
- Four 5-beat packets, m_axis_tready=1 → output identical and in order, first m_axis_tvalid 3 cycles after the first tlast, drop_count=0.
- m_axis_tready=0 and three 6-beat packets → packets 1–2 kept, packet 3 overflows at beat 5. drop_count=1, pkt_count=2. Release tready: only 12 beats emerge.
- A 20-beat packet into an empty FIFO → dropped, drop_pulse once, fill_level returns to 0, next 3-beat packet passes.
- A 4-beat packet with s_axis_tuser_err=1 on tlast → not output, drop_count=1, wr_p restored. The following packet starts at the same RAM address.
- 200 random-length (1–8 beats) packets with random m_axis_tready at 50% → no loss or reorder, data stable under backpressure, pointers wrap more than 10 times.
- aresetn low for 2 cycles mid-packet with a packet queued → all outputs at reset values. Post-reset packet delivered intact, drop_count=0.

Source files
------------

// File: rtl/pkt_fifo_pkg.sv
// Shared types and sizing helpers for the store-and-forward packet FIFO.
package pkt_fifo_pkg;

    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } wr_state_e;

    // Pointers carry one extra bit so that full and empty stay distinguishable.
    function automatic int ptr_width(input int depth_bits);
        return depth_bits + 1;
    endfunction

    // Width of one stored beat record {data, last, mty}.
    function automatic int beat_width(input int data_w, input int mty_w);
        return data_w + 1 + mty_w;
    endfunction

endpackage

// File: rtl/pkt_fifo_sf_if.sv
// AXI-Stream beat bundle used on both the ingress and egress side of the FIFO.
interface pkt_fifo_sf_if #(
    parameter int C_DATA_WIDTH = 256,
    parameter int C_MTY_WIDTH  = 5
);
    logic                    tvalid;
    logic                    tready;
    logic [C_DATA_WIDTH-1:0] tdata;
    logic                    tlast;
    logic [C_MTY_WIDTH-1:0]  tuser_mty;
    logic                    tuser_err;

    modport master (
        output tvalid, tdata, tlast, tuser_mty, tuser_err,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tlast, tuser_mty, tuser_err,
        output tready
    );
endinterface

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port inferred RAM with a registered read port (1-cycle latency).
module pkt_fifo_ram #(
    parameter int C_WIDTH     = 8,
    parameter int C_ADDR_BITS = 4
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [C_ADDR_BITS-1:0] waddr,
    input  logic [C_WIDTH-1:0]     wdata,
    input  logic                   re,
    input  logic [C_ADDR_BITS-1:0] raddr,
    output logic [C_WIDTH-1:0]     rdata
);
    logic [C_WIDTH-1:0] mem [2**C_ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/pkt_fifo_sf.sv
// Store-and-forward AXI-Stream packet FIFO: packets are committed on a clean tlast,
// rolled back on overflow or error, and only committed packets reach the egress.
module pkt_fifo_sf
    import pkt_fifo_pkg::*;
#(
    parameter int C_DATA_WIDTH = 256,
    parameter int C_MTY_WIDTH  = 5,
    parameter int C_DEPTH_BITS = 9,
    parameter int C_CNT_WIDTH  = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    pkt_fifo_sf_if.slave            s_axis,
    pkt_fifo_sf_if.master           m_axis,
    output logic [C_DEPTH_BITS:0]   fill_level,
    output logic [C_DEPTH_BITS:0]   pkt_count,
    output logic [C_CNT_WIDTH-1:0]  drop_count,
    output logic                    drop_pulse
);
    localparam int PW = ptr_width(C_DEPTH_BITS);
    localparam int BW = beat_width(C_DATA_WIDTH, C_MTY_WIDTH);
    localparam logic [PW-1:0] DEPTH   = {1'b1, {C_DEPTH_BITS{1'b0}}};
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [C_DATA_WIDTH-1:0] data;
        logic                    last;
        logic [C_MTY_WIDTH-1:0]  mty;
    } beat_t;

    wr_state_e state_q, state_d;
    logic [PW-1:0] wr_p_q, wr_p_d, wr_commit_q, wr_commit_d;
    logic [PW-1:0] rd_p_q, rd_p_d, fetch_p_q, fetch_p_d, commit_seen_q, commit_seen_d;
    logic [PW-1:0] fill_q, fill_d, pkt_q, pkt_d;
    logic [C_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic drop_pulse_q, drop_pulse_d;
    logic [1:0] occ_q, occ_d;
    logic inflight_q, inflight_d;
    beat_t slot0_q, slot0_d, slot1_q, slot1_d;
    beat_t wr_beat, ram_rdata;
    logic [BW-1:0] ram_rdata_raw;
    logic ram_we, ram_re, full, commit, present, push, pop, retire;
    logic [2:0] used;

    pkt_fifo_ram #(.C_WIDTH(BW), .C_ADDR_BITS(C_DEPTH_BITS)) u_ram (
        .clk   (aclk),
        .we    (ram_we),
        .waddr (wr_p_q[C_DEPTH_BITS-1:0]),
        .wdata (wr_beat),
        .re    (ram_re),
        .raddr (fetch_p_q[C_DEPTH_BITS-1:0]),
        .rdata (ram_rdata_raw)
    );

    assign ram_rdata = beat_t'(ram_rdata_raw);

    // Full is judged against the egress-retired pointer, so beats parked in the
    // skid buffer still occupy buffer space until they are handed downstream.
    always_comb begin
        state_d      = state_q;
        wr_p_d       = wr_p_q;
        wr_commit_d  = wr_commit_q;
        ram_we       = 1'b0;
        commit       = 1'b0;
        drop_pulse_d = 1'b0;
        wr_beat.data = s_axis.tdata;
        wr_beat.last = s_axis.tlast;
        wr_beat.mty  = s_axis.tuser_mty;
        full         = (wr_p_q - rd_p_q) == DEPTH;
        unique case (state_q)
            ACCEPT: begin
                if (s_axis.tvalid) begin
                    if (!full) begin
                        ram_we = 1'b1;
                        wr_p_d = wr_p_q + PTR_ONE;
                        if (s_axis.tlast) begin
                            if (s_axis.tuser_err) begin
                                wr_p_d       = wr_commit_q;
                                drop_pulse_d = 1'b1;
                            end else begin
                                wr_commit_d = wr_p_q + PTR_ONE;
                                commit      = 1'b1;
                            end
                        end
                    end else begin
                        wr_p_d = wr_commit_q;
                        if (s_axis.tlast) begin
                            drop_pulse_d = 1'b1;
                        end else begin
                            state_d = DISCARD;
                        end
                    end
                end
            end
            DISCARD: begin
                if (s_axis.tvalid && s_axis.tlast) begin
                    drop_pulse_d = 1'b1;
                    state_d      = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
        drop_cnt_d = drop_cnt_q;
        if (drop_pulse_d && (drop_cnt_q != {C_CNT_WIDTH{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Prefetch into the 2-entry skid: a read is issued only when the skid plus the
    // read in flight still leave room after this cycle's handshake.
    always_comb begin
        commit_seen_d = wr_commit_q;
        pop        = (occ_q != 2'd0) && m_axis.tready;
        push       = inflight_q;
        retire     = pop && slot0_q.last;
        present    = fetch_p_q != commit_seen_q;
        used       = {1'b0, occ_q} + {2'b00, inflight_q};
        ram_re     = present && (used < (3'd2 + {2'b00, pop}));
        fetch_p_d  = fetch_p_q + {{(PW-1){1'b0}}, ram_re};
        inflight_d = ram_re;
        rd_p_d     = rd_p_q + {{(PW-1){1'b0}}, pop};
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        if (pop) begin
            if (occ_q == 2'd2) begin
                slot0_d = slot1_q;
                if (push) begin
                    slot1_d = ram_rdata;
                end
            end else if (push) begin
                slot0_d = ram_rdata;
            end
        end else if (push) begin
            if (occ_q == 2'd0) begin
                slot0_d = ram_rdata;
            end else begin
                slot1_d = ram_rdata;
            end
        end
        pkt_d  = pkt_q + {{(PW-1){1'b0}}, commit} - {{(PW-1){1'b0}}, retire};
        fill_d = wr_p_d - rd_p_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ACCEPT;
            wr_p_q        <= '0;
            wr_commit_q   <= '0;
            rd_p_q        <= '0;
            fetch_p_q     <= '0;
            commit_seen_q <= '0;
            fill_q        <= '0;
            pkt_q         <= '0;
            drop_cnt_q    <= '0;
            drop_pulse_q  <= 1'b0;
            occ_q         <= 2'd0;
            inflight_q    <= 1'b0;
            slot0_q       <= '0;
            slot1_q       <= '0;
        end else begin
            state_q       <= state_d;
            wr_p_q        <= wr_p_d;
            wr_commit_q   <= wr_commit_d;
            rd_p_q        <= rd_p_d;
            fetch_p_q     <= fetch_p_d;
            commit_seen_q <= commit_seen_d;
            fill_q        <= fill_d;
            pkt_q         <= pkt_d;
            drop_cnt_q    <= drop_cnt_d;
            drop_pulse_q  <= drop_pulse_d;
            occ_q         <= occ_d;
            inflight_q    <= inflight_d;
            slot0_q       <= slot0_d;
            slot1_q       <= slot1_d;
        end
    end

    assign s_axis.tready    = aresetn;
    assign m_axis.tvalid    = occ_q != 2'd0;
    assign m_axis.tdata     = slot0_q.data;
    assign m_axis.tlast     = slot0_q.last;
    assign m_axis.tuser_mty = slot0_q.mty;
    assign m_axis.tuser_err = 1'b0;
    assign fill_level       = fill_q;
    assign pkt_count        = pkt_q;
    assign drop_count       = drop_cnt_q;
    assign drop_pulse       = drop_pulse_q;
endmodule
